// File: rtl/d_write_buffer_if.sv
// Store-side, memory-side and probe signals of the D-cache write buffer.
// The buffer uses the slave view; producer, arbiter and fill FSM use the master view.
interface d_write_buffer_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              full;
    logic              empty;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic              mem_ack;
    logic [ADDR_W-1:0] probe_addr;
    logic              probe_hit;

    modport slave (
        input  wr_en, wr_addr, wr_data, mem_ack, probe_addr,
        output full, empty, mem_req, mem_addr, mem_data, probe_hit
    );

    modport master (
        output wr_en, wr_addr, wr_data, mem_ack, probe_addr,
        input  full, empty, mem_req, mem_addr, mem_data, probe_hit
    );
endinterface

// File: rtl/d_write_buffer.sv
// D-cache write buffer: single-cycle store enqueue with same-address coalescing,
// FIFO drain to the memory arbiter over req/ack, and a block-address probe for the fill FSM.
module d_write_buffer #(
    parameter int DEPTH   = 4,
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int BLK_OFF = 4
) (
    input  logic            clk,
    input  logic            rst,
    d_write_buffer_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [ADDR_W-1:0] BLK_MASK = {ADDR_W{1'b1}} << BLK_OFF;

    typedef enum logic {IDLE, ISSUE} state_t;

    state_t            state_reg, state_next;
    logic [PTR_W-1:0]  head_reg, head_next;
    logic [PTR_W-1:0]  tail_reg, tail_next;
    logic [CNT_W-1:0]  count_reg, count_next;

    logic [ADDR_W-1:0] addr_mem [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];

    logic [DEPTH-1:0]  slot_valid;
    logic [DEPTH-1:0]  slot_match;
    logic [DEPTH-1:0]  slot_coal;
    logic [DEPTH-1:0]  slot_probe;
    logic [PTR_W-1:0]  coal_idx;
    logic              accept, coalesce, push, pop;

    // A slot is live when its distance from head (mod DEPTH) is below count.
    // The in-flight head is excluded from coalescing so the data on the bus stays stable.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
        logic [PTR_W-1:0] rel;
        assign rel            = PTR_W'(gi) - head_reg;
        assign slot_valid[gi] = {1'b0, rel} < count_reg;
        assign slot_match[gi] = slot_valid[gi] && (addr_mem[gi] == bus.wr_addr);
        assign slot_coal[gi]  = slot_match[gi] &&
                                !((state_reg == ISSUE) && (head_reg == PTR_W'(gi)));
        assign slot_probe[gi] = slot_valid[gi] &&
                                (((addr_mem[gi] ^ bus.probe_addr) & BLK_MASK) == '0);
    end

    always_comb begin
        coal_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (slot_coal[i]) coal_idx = PTR_W'(i);
        end
    end

    assign accept   = bus.wr_en && (count_reg != CNT_W'(DEPTH));
    assign coalesce = accept && (|slot_coal);
    assign push     = accept && !coalesce;
    assign pop      = (state_reg == ISSUE) && bus.mem_ack;

    always_comb begin
        head_next  = pop  ? head_reg + PTR_W'(1) : head_reg;
        tail_next  = push ? tail_reg + PTR_W'(1) : tail_reg;
        count_next = count_reg + CNT_W'(push) - CNT_W'(pop);
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (count_reg != '0) state_next = ISSUE;
            ISSUE:   if (pop && (count_next == '0)) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            state_reg <= state_next;
            head_reg  <= head_next;
            tail_reg  <= tail_next;
            count_reg <= count_next;
        end
    end

    // Entry storage carries no reset; liveness comes from head/count only.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[tail_reg] <= bus.wr_addr;
            data_mem[tail_reg] <= bus.wr_data;
        end else if (coalesce) begin
            data_mem[coal_idx] <= bus.wr_data;
        end
    end

    assign bus.full      = (count_reg == CNT_W'(DEPTH));
    assign bus.empty     = (count_reg == '0);
    assign bus.mem_req   = (state_reg == ISSUE);
    assign bus.mem_addr  = addr_mem[head_reg];
    assign bus.mem_data  = data_mem[head_reg];
    assign bus.probe_hit = |slot_probe;
endmodule

// File: tb/tb_d_write_buffer.sv
// Bench for d_write_buffer: queue-level reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_d_write_buffer;
    localparam int DEPTH   = 4;
    localparam int ADDR_W  = 16;
    localparam int DATA_W  = 16;
    localparam int BLK_OFF = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    d_write_buffer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    d_write_buffer #(
        .DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BLK_OFF(BLK_OFF)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } ent_t;

    ent_t mq[$];      // buffered stores, oldest first
    ent_t wlog[$];    // writes the memory has completed
    bit   m_issue = 1'b0;
    bit   m_live  = 1'b0;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, exp);
        end
    endtask

    // Reference model: a queue of stores; the head is on the bus once a cycle
    // of non-empty idle time has passed, and stays there until acknowledged.
    always @(posedge clk) begin : model_upd
        int   sz0;
        int   ci;
        bit   popped;
        bit   take;
        ent_t e;
        if (rst) begin
            mq.delete();
            m_issue = 1'b0;
            m_live  = 1'b1;
        end else if (m_live) begin
            sz0    = mq.size();
            popped = m_issue && (bus.mem_ack === 1'b1);
            take   = (bus.wr_en === 1'b1) && (sz0 < DEPTH);
            ci     = -1;
            if (take) begin
                for (int j = 0; j < sz0; j++)
                    if (mq[j].addr == bus.wr_addr && !(j == 0 && m_issue)) ci = j;
                if (ci >= 0) begin
                    e       = mq[ci];
                    e.data  = bus.wr_data;
                    mq[ci]  = e;
                end
            end
            if (popped) begin
                wlog.push_back(mq[0]);
                $display("mem write addr=%h data=%h t=%0t", mq[0].addr, mq[0].data, $time);
                void'(mq.pop_front());
            end
            if (take && ci < 0) begin
                e.addr = bus.wr_addr;
                e.data = bus.wr_data;
                mq.push_back(e);
            end
            if (!m_issue)    m_issue = (sz0 != 0);
            else if (popped) m_issue = (mq.size() != 0);
            assert (mq.size() <= DEPTH) else $error("model occupancy above DEPTH");
        end
    end

    always @(negedge clk) begin : compare
        bit hit;
        if (m_live) begin
            hit = 1'b0;
            foreach (mq[j])
                if (mq[j].addr[ADDR_W-1:BLK_OFF] == bus.probe_addr[ADDR_W-1:BLK_OFF]) hit = 1'b1;
            cmp("m_empty", bus.empty, mq.size() == 0);
            cmp("m_full", bus.full, mq.size() == DEPTH);
            cmp("m_mem_req", bus.mem_req, m_issue);
            cmp("m_probe_hit", bus.probe_hit, hit);
            if (m_issue && mq.size() > 0) begin
                cmp("m_mem_addr", bus.mem_addr, mq[0].addr);
                cmp("m_mem_data", bus.mem_data, mq[0].data);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        bus.wr_en   = 1'b1;
        bus.wr_addr = a;
        bus.wr_data = d;
        tick();
        bus.wr_en   = 1'b0;
    endtask

    task automatic wait_req(input int budget);
        int n = 0;
        while (bus.mem_req !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        cmp("wait_req_timeout", bus.mem_req, 1'b1);
    endtask

    task automatic log_chk(input string name, input int back,
                           input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        int n = wlog.size();
        ent_t e = '0;
        if (n >= back) e = wlog[n-back];
        cmp({name, "_addr"}, e.addr, a);
        cmp({name, "_data"}, e.data, d);
    endtask

    initial begin
        int n0;
        rst            = 1'b1;
        bus.wr_en      = 1'b0;
        bus.wr_addr    = '0;
        bus.wr_data    = '0;
        bus.mem_ack    = 1'b0;
        bus.probe_addr = 16'hFFF0;
        tick();
        tick();
        rst = 1'b0;

        // Reset then idle
        repeat (5) tick();
        cmp("t1_empty", bus.empty, 1'b1);
        cmp("t1_full", bus.full, 1'b0);
        cmp("t1_mem_req", bus.mem_req, 1'b0);
        cmp("t1_probe_hit", bus.probe_hit, 1'b0);

        // Single store, ack four cycles after mem_req rises
        put(16'h0010, 16'hBEEF);
        cmp("t2_empty_after_enq", bus.empty, 1'b0);
        cmp("t2_req_not_yet", bus.mem_req, 1'b0);
        tick();
        cmp("t2_req", bus.mem_req, 1'b1);
        cmp("t2_addr", bus.mem_addr, 16'h0010);
        cmp("t2_data", bus.mem_data, 16'hBEEF);
        repeat (3) tick();
        cmp("t2_req_held", bus.mem_req, 1'b1);
        bus.mem_ack = 1'b1;
        tick();
        bus.mem_ack = 1'b0;
        cmp("t2_empty_after_ack", bus.empty, 1'b1);
        cmp("t2_req_after_ack", bus.mem_req, 1'b0);
        log_chk("t2_log", 1, 16'h0010, 16'hBEEF);

        // Fill to DEPTH, drop a fifth store, drain back-to-back
        for (int i = 0; i < 4; i++) put(16'h0020 + 16'(2*i), 16'hA000 + 16'(i));
        cmp("t3_full", bus.full, 1'b1);
        bus.wr_en = 1'b1; bus.wr_addr = 16'h0028; bus.wr_data = 16'hDEAD;
        tick();
        bus.wr_en = 1'b0;
        cmp("t3_still_full", bus.full, 1'b1);
        n0 = wlog.size();
        for (int i = 0; i < 4; i++) begin
            cmp("t3_no_bubble_req", bus.mem_req, 1'b1);
            cmp("t3_drain_addr", bus.mem_addr, 16'h0020 + 16'(2*i));
            bus.mem_ack = 1'b1;
            tick();
        end
        bus.mem_ack = 1'b0;
        cmp("t3_empty", bus.empty, 1'b1);
        cmp("t3_write_count", wlog.size() - n0, 4);
        for (int i = 0; i < 4; i++)
            log_chk("t3_log", 4 - i, 16'h0020 + 16'(2*i), 16'hA000 + 16'(i));

        // Coalesce into a non-head entry while the head is in flight
        put(16'h0030, 16'h1111);
        put(16'h0032, 16'h2222);
        cmp("t4_inflight_addr", bus.mem_addr, 16'h0030);
        put(16'h0032, 16'h3333);
        cmp("t4_not_full", bus.full, 1'b0);
        cmp("t4_req1", bus.mem_req, 1'b1);
        bus.mem_ack = 1'b1;
        tick();
        bus.mem_ack = 1'b0;
        cmp("t4_req2", bus.mem_req, 1'b1);
        cmp("t4_second_data", bus.mem_data, 16'h3333);
        bus.mem_ack = 1'b1;
        tick();
        bus.mem_ack = 1'b0;
        cmp("t4_empty", bus.empty, 1'b1);
        log_chk("t4_log0", 2, 16'h0030, 16'h1111);
        log_chk("t4_log1", 1, 16'h0032, 16'h3333);

        // Block probe
        put(16'h0044, 16'h5555);
        bus.probe_addr = 16'h0040; #1;
        cmp("t5_hit_same_block", bus.probe_hit, 1'b1);
        tick();
        bus.probe_addr = 16'h0050; #1;
        cmp("t5_miss_other_block", bus.probe_hit, 1'b0);
        tick();
        bus.probe_addr = 16'h0040; #1;
        cmp("t5_hit_again", bus.probe_hit, 1'b1);
        wait_req(8);
        bus.mem_ack = 1'b1;
        tick();
        bus.mem_ack = 1'b0; #1;
        cmp("t5_hit_drops", bus.probe_hit, 1'b0);

        // Reset mid-drain, then a late ack
        put(16'h0060, 16'h6060);
        put(16'h0062, 16'h6262);
        put(16'h0064, 16'h6464);
        wait_req(8);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        cmp("t6_empty", bus.empty, 1'b1);
        cmp("t6_req", bus.mem_req, 1'b0);
        bus.mem_ack = 1'b1;
        tick();
        bus.mem_ack = 1'b0;
        repeat (3) tick();
        cmp("t6_empty_late_ack", bus.empty, 1'b1);
        cmp("t6_req_late_ack", bus.mem_req, 1'b0);
        cmp("t6_full_late_ack", bus.full, 1'b0);

        // Randomized traffic over a few blocks to exercise coalescing and wrap
        for (int c = 0; c < 800; c++) begin
            bus.wr_en      = ($urandom_range(0, 1) == 1);
            bus.wr_addr    = (($urandom_range(0, 1) == 1) ? 16'h0100 : 16'h0200)
                             + 16'(2 * $urandom_range(0, 4));
            bus.wr_data    = 16'($urandom);
            bus.probe_addr = (($urandom_range(0, 1) == 1) ? 16'h0100 : 16'h0200)
                             + 16'($urandom_range(0, 31));
            if (bus.mem_req === 1'b1) bus.mem_ack = ($urandom_range(0, 2) == 0);
            else                      bus.mem_ack = ($urandom_range(0, 9) == 0);
            rst = ($urandom_range(0, 199) == 0);
            tick();
        end
        rst         = 1'b0;
        bus.wr_en   = 1'b0;
        bus.mem_ack = 1'b1;
        repeat (8) tick();
        bus.mem_ack = 1'b0;
        tick();
        cmp("end_empty", bus.empty, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
